// File: rtl/vtg_pkg.sv
// Shared timing defaults and window decode for the raster timing generator.
package vtg_pkg;

  localparam int unsigned M72_H_TOTAL       = 512;
  localparam int unsigned M72_H_BLANK_END   = 64;
  localparam int unsigned M72_H_BLANK_START = 448;
  localparam int unsigned M72_HS_START      = 491;
  localparam int unsigned M72_HS_END        = 20;
  localparam int unsigned M72_V_TOTAL       = 284;
  localparam int unsigned M72_V_ACTIVE      = 256;
  localparam int unsigned M72_VS_START      = 270;
  localparam int unsigned M72_VS_END        = 276;
  localparam int unsigned M72_V_OFFSET      = 128;

  // A window whose start lies past its end wraps through zero.
  function automatic logic in_window(input int unsigned pos,
                                     input int unsigned win_start,
                                     input int unsigned win_end);
    if (win_start > win_end) return (pos >= win_start) || (pos < win_end);
    else                     return (pos >= win_start) && (pos < win_end);
  endfunction

endpackage

// File: rtl/vtg_axis.sv
// One raster axis: wrapping counter with carry-out and registered position,
// blank and sync decode. Counting (inc_i) and output update (ce_i) are separate.
module vtg_axis
  import vtg_pkg::*;
#(
  parameter int unsigned W           = 10,
  parameter int unsigned TOTAL       = 512,
  parameter int unsigned BLANK_START = 448,
  parameter int unsigned BLANK_END   = 64,
  parameter int unsigned SYNC_START  = 491,
  parameter int unsigned SYNC_END    = 20
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         ce_i,
  output logic [W-1:0] cnt_o,
  output logic         carry_o,
  output logic [W-1:0] pos_o,
  output logic         blank_o,
  output logic         sync_o
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] pos_q;
  logic         blank_q, sync_q;

  assign carry_o = inc_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = carry_o ? '0 : cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      pos_q   <= '0;
      blank_q <= in_window(0, BLANK_START, BLANK_END);
      sync_q  <= in_window(0, SYNC_START, SYNC_END);
    end else begin
      cnt_q <= cnt_d;
      if (ce_i) begin
        pos_q   <= cnt_q;
        blank_q <= in_window(32'(cnt_q), BLANK_START, BLANK_END);
        sync_q  <= in_window(32'(cnt_q), SYNC_START, SYNC_END);
      end
    end
  end

  assign cnt_o   = cnt_q;
  assign pos_o   = pos_q;
  assign blank_o = blank_q;
  assign sync_o  = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with NUM_CMP raster-line compare interrupts.
// Define VTG_IRQ_ACK_EN for sticky, acknowledged interrupts instead of pulses.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned HW            = 10,
  parameter int unsigned VW            = 9,
  parameter int unsigned H_TOTAL       = M72_H_TOTAL,
  parameter int unsigned H_BLANK_END   = M72_H_BLANK_END,
  parameter int unsigned H_BLANK_START = M72_H_BLANK_START,
  parameter int unsigned HS_START      = M72_HS_START,
  parameter int unsigned HS_END        = M72_HS_END,
  parameter int unsigned V_TOTAL       = M72_V_TOTAL,
  parameter int unsigned V_ACTIVE      = M72_V_ACTIVE,
  parameter int unsigned VS_START      = M72_VS_START,
  parameter int unsigned VS_END        = M72_VS_END,
  parameter int unsigned V_OFFSET      = M72_V_OFFSET,
  parameter int unsigned NUM_CMP       = 2,
  parameter int unsigned CMP_HPOS      = 0,
  localparam int unsigned AW           = (NUM_CMP > 1) ? $clog2(NUM_CMP) : 1
) (
  input  logic               CLK_32M,
  input  logic               RESET_N,
  input  logic               CE_PIX,
  input  logic               WR,
  input  logic [AW-1:0]      ADDR,
  input  logic [VW-1:0]      D,
  input  logic [NUM_CMP-1:0] IRQ_ACK,
  output logic [HW-1:0]      H,
  output logic [HW-1:0]      HE,
  output logic [VW-1:0]      V,
  output logic [VW-1:0]      VE,
  output logic               HBLK,
  output logic               VBLK,
  output logic               HS,
  output logic               VS,
  output logic [NUM_CMP-1:0] HINT
);

  logic [HW-1:0]      h_cnt, h_pos;
  logic [VW-1:0]      v_cnt;
  logic               h_carry, v_carry_unused;
  logic [VW-1:0]      ve_now, ve_q;
  logic [VW-1:0]      cmp_q [NUM_CMP];
  logic [NUM_CMP-1:0] match;
  logic [NUM_CMP-1:0] hint_q, hint_d;

  vtg_axis #(
    .W(HW), .TOTAL(H_TOTAL),
    .BLANK_START(H_BLANK_START), .BLANK_END(H_BLANK_END),
    .SYNC_START(HS_START), .SYNC_END(HS_END)
  ) u_h_axis (
    .clk_i(CLK_32M), .rst_ni(RESET_N), .inc_i(CE_PIX), .ce_i(CE_PIX),
    .cnt_o(h_cnt), .carry_o(h_carry), .pos_o(h_pos), .blank_o(HBLK), .sync_o(HS)
  );

  // Vertical blank window runs from V_ACTIVE to the end of the frame.
  vtg_axis #(
    .W(VW), .TOTAL(V_TOTAL),
    .BLANK_START(V_ACTIVE), .BLANK_END(0),
    .SYNC_START(VS_START), .SYNC_END(VS_END)
  ) u_v_axis (
    .clk_i(CLK_32M), .rst_ni(RESET_N), .inc_i(h_carry), .ce_i(CE_PIX),
    .cnt_o(v_cnt), .carry_o(v_carry_unused), .pos_o(V), .blank_o(VBLK), .sync_o(VS)
  );

  assign ve_now = v_cnt + VW'(V_OFFSET);

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CMP; i++)
      match[i] = CE_PIX && (h_cnt == HW'(CMP_HPOS)) && (ve_now == cmp_q[i]);
  end

  // NOTE: the compare bank is reset on purpose: all ones is a line VE never
  // reaches at the default timing, so a fresh part raises no interrupts.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= '1;
    end else if (WR && (32'(ADDR) < NUM_CMP)) begin
      cmp_q[ADDR] <= D;
    end
  end

  always_comb begin
    hint_d = hint_q;
`ifdef VTG_IRQ_ACK_EN
    hint_d = (hint_q & ~IRQ_ACK) | match;
`else
    if (CE_PIX) hint_d = match;
`endif
  end

`ifndef VTG_IRQ_ACK_EN
  logic unused_ack;
  assign unused_ack = ^IRQ_ACK;
`endif

  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      ve_q   <= VW'(V_OFFSET);
      hint_q <= '0;
    end else begin
      hint_q <= hint_d;
      if (CE_PIX) ve_q <= ve_now;
    end
  end

  assign H    = h_pos;
  assign HE   = h_pos;
  assign VE   = ve_q;
  assign HINT = hint_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen with a shortened line and default vertical timing.
module tb_video_timing_gen;

  localparam int HT = 40, HBE = 4, HBS = 32, HSS = 36, HSE = 2;
  localparam int VT = 284, VA = 256, VSS = 270, VSE = 276, VOFF = 128;
  localparam int NC = 2, CHP = 0;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] he;
    logic [8:0] v;
    logic [8:0] ve;
    logic       hblk;
    logic       vblk;
    logic       hs;
    logic       vs;
    logic [1:0] hint;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n, ce, wr;
  logic [0:0] addr;
  logic [8:0] d;
  logic [1:0] ack;
  logic [9:0] H, HE;
  logic [8:0] V, VE;
  logic       HBLK, VBLK, HS, VS;
  logic [1:0] irq;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_TOTAL(HT), .H_BLANK_END(HBE), .H_BLANK_START(HBS),
    .HS_START(HSS), .HS_END(HSE), .V_TOTAL(VT), .V_ACTIVE(VA),
    .VS_START(VSS), .VS_END(VSE), .V_OFFSET(VOFF),
    .NUM_CMP(NC), .CMP_HPOS(CHP)
  ) dut (
    .CLK_32M(clk), .RESET_N(rst_n), .CE_PIX(ce), .WR(wr), .ADDR(addr), .D(d),
    .IRQ_ACK(ack), .H(H), .HE(HE), .V(V), .VE(VE), .HBLK(HBLK), .VBLK(VBLK),
    .HS(HS), .VS(VS), .HINT(irq)
  );

  int   n_asserts = 0, n_fail = 0;
  out_t sb_q[$];
  int   m_h, m_v;
  logic [8:0] m_cmp [NC];
  out_t m_out, prev_o, snap;
  int   pulse_cnt [NC], last_v [NC], last_h [NC];
  int   wraps, max_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic win(input int p, input int s, input int e);
    return (s > e) ? (p >= s || p < e) : (p >= s && p < e);
  endfunction

  function automatic out_t decode(input int h, input int v, input logic [1:0] hint);
    out_t o;
    o.h = 10'(h); o.he = 10'(h); o.v = 9'(v); o.ve = 9'(v + VOFF);
    o.hblk = (h < HBE) || (h >= HBS);
    o.vblk = (v >= VA);
    o.hs = win(h, HSS, HSE);
    o.vs = win(v, VSS, VSE);
    o.hint = hint;
    return o;
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < NC; i++) begin
      pulse_cnt[i] = 0; last_v[i] = -1; last_h[i] = -1;
    end
    wraps = 0; max_v = 0;
  endtask

  // One clock: drive inputs, predict the post-edge outputs, then compare.
  task automatic tick(input logic r, input logic c, input logic w,
                      input logic [0:0] a, input logic [8:0] dd, input logic [1:0] k);
    logic [1:0] mt, nh;
    out_t obs, e;
    rst_n = r; ce = c; wr = w; addr = a; d = dd; ack = k;
    if (!r) begin
      m_h = 0; m_v = 0;
      for (int i = 0; i < NC; i++) m_cmp[i] = '1;
      m_out = decode(0, 0, 2'b00);
    end else begin
      for (int i = 0; i < NC; i++)
        mt[i] = c && (m_h == CHP) && (9'(m_v + VOFF) == m_cmp[i]);
`ifdef VTG_IRQ_ACK_EN
      nh = (m_out.hint & ~k) | mt;
`else
      nh = c ? mt : m_out.hint;
`endif
      if (c) begin
        m_out = decode(m_h, m_v, nh);
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
      end else begin
        m_out.hint = nh;
      end
      if (w && int'(a) < NC) m_cmp[a] = dd;
    end
    sb_q.push_back(m_out);
    @(posedge clk);
    #1;
    obs = {H, HE, V, VE, HBLK, VBLK, HS, VS, irq};
    e = sb_q.pop_front();
    check("cycle", obs, e);
    if (r) begin
      if (prev_o.hblk && !HBLK) check("hblk_fall_h", H, HBE);
      if (!prev_o.hblk && HBLK) check("hblk_rise_h", H, HBS);
      if (!prev_o.hs && HS)     check("hs_rise_h", H, HSS);
      if (prev_o.hs && !HS)     check("hs_fall_h", H, HSE);
      if (!prev_o.vs && VS)     check("vs_rise_v", V, VSS);
      if (prev_o.vs && !VS)     check("vs_fall_v", V, VSE);
      if (!prev_o.vblk && VBLK) check("vblk_rise_v", V, VA);
      if (prev_o.v == 9'(VT - 1) && V == 9'd0) wraps++;
      if (int'(V) > max_v) max_v = int'(V);
      for (int i = 0; i < NC; i++)
        if (irq[i] && !prev_o.hint[i]) begin
          pulse_cnt[i]++; last_v[i] = int'(V); last_h[i] = int'(H);
        end
    end
    prev_o = obs;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 2'b00);
  endtask

  // Advance with CE until the internal position is (h, v); v < 0 matches any line.
  task automatic advance_to(input int h, input int v);
    int guard = 0;
    while (!(m_h == h && (v < 0 || m_v == v)) && guard <= HT * VT) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 2'b00);
      guard++;
    end
    check("advance_reach", guard <= HT * VT, 1);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; wr = 1'b0; addr = '0; d = '0; ack = '0;
    prev_o = '0;
    clear_stats();

    // Reset state
    tick(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 2'b00);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 2'b00);
    check("rst_H", H, 0);
    check("rst_HE", HE, 0);
    check("rst_V", V, 0);
    check("rst_VE", VE, 128);
    check("rst_HBLK", HBLK, 1);
    check("rst_VBLK", VBLK, 0);
    check("rst_HS", HS, 1);
    check("rst_VS", VS, 0);
    check("rst_irq", irq, 0);

    // Free-run one full frame
    clear_stats();
    run(HT * VT + 5);
    check("frame_wraps", wraps, 1);
    check("frame_max_v", max_v, VT - 1);
    check("frame_no_irq0", pulse_cnt[0], 0);
    check("frame_no_irq1", pulse_cnt[1], 0);

    // cmp[1] = 200 gives a single line-72 interrupt per frame
    tick(1'b1, 1'b0, 1'b1, 1'b1, 9'd200, 2'b00);
    clear_stats();
    run(HT * VT);
    check("cmp1_pulses", pulse_cnt[1], 1);
    check("cmp1_line", last_v[1], 72);
    check("cmp1_hpos", last_h[1], CHP);
    check("cmp0_silent", pulse_cnt[0], 0);

    // CE held low mid-line
    advance_to(20, -1);
    run(1);
    snap = {H, HE, V, VE, HBLK, VBLK, HS, VS, irq};
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 2'b00);
    check("freeze_all", {H, HE, V, VE, HBLK, VBLK, HS, VS, irq}, snap);
    run(1);
    check("resume_h", H, snap.h + 10'd1);
    check("resume_v", V, snap.v);

    // Write cmp[0] on the cycle its old value matches
    tick(1'b1, 1'b0, 1'b1, 1'b0, 9'd138, 2'b00);
    advance_to(CHP, 10);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 9'd148, 2'b00);
    check("old_match_fires", irq[0], 1);
    check("old_match_line", V, 10);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 2'b01);
    clear_stats();
    advance_to(CHP + 1, 20);
    check("new_cmp_pulses", pulse_cnt[0], 1);
    check("new_cmp_line", last_v[0], 20);

`ifdef VTG_IRQ_ACK_EN
    // Sticky interrupt: holds until acked, match beats a coincident ack
    run(50);
    check("sticky_hold", irq[0], 1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 2'b01);
    check("sticky_ack", irq[0], 0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 9'd158, 2'b00);
    advance_to(CHP, 30);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 2'b01);
    check("match_beats_ack", irq[0], 1);
    run(1);
    check("sticky_after", irq[0], 1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 2'b11);
    check("sticky_clear_all", irq, 0);
`endif

    // Mid-frame reset
    advance_to(30, 150);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 2'b00);
    check("mrst_H", H, 0);
    check("mrst_V", V, 0);
    check("mrst_VE", VE, 128);
    check("mrst_HBLK", HBLK, 1);
    check("mrst_irq", irq, 0);
    clear_stats();
    advance_to(0, 80);
    check("mrst_cmp0_cleared", pulse_cnt[0], 0);
    check("mrst_cmp1_cleared", pulse_cnt[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
